// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: operands and opcode in, registered result and flags out.
interface alu_seq_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic              i_valid;
    logic              o_ready;
    logic [N_BITS-1:0] i_a;
    logic [N_BITS-1:0] i_b;
    logic [N_OP-1:0]   i_op;
    logic              o_valid;
    logic              i_ready;
    logic [N_BITS-1:0] o_result;
    logic [3:0]        o_flags;

    modport slave (
        input  i_valid, i_a, i_b, i_op, i_ready,
        output o_ready, o_valid, o_result, o_flags
    );

    modport master (
        output i_valid, i_a, i_b, i_op, i_ready,
        input  o_ready, o_valid, o_result, o_flags
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; flags are {err, ovf, carry, zero}.
// Define ALU_SEQ_MUL_EN to add the iterative signed multiply (opcode 011000).
module alu_seq #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int MSB = N_BITS - 1;
    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_SLL = N_OP'(6'b000000);
    localparam logic [N_OP-1:0] OP_SLT = N_OP'(6'b101010);

`ifdef ALU_SEQ_MUL_EN
    localparam logic [N_OP-1:0] OP_MUL = N_OP'(6'b011000);
    localparam int CW = $clog2(N_BITS);
    typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_t;
`else
    typedef enum logic { ST_IDLE = 1'b0 } state_t;
`endif

    state_t            state_r;
    logic              valid_r;
    logic [N_BITS-1:0] result_r;
    logic [3:0]        flags_r;

    logic [N_BITS-1:0] res_s;
    logic              ovf_s;
    logic              carry_s;
    logic              err_s;
    logic [N_BITS:0]   sum_s;
    logic [N_BITS:0]   diff_s;
    logic [31:0]       amt_s;

`ifdef ALU_SEQ_MUL_EN
    logic [2*N_BITS-1:0] acc_r;
    logic [2*N_BITS-1:0] mcand_r;
    logic [N_BITS-1:0]   mplier_r;
    logic [CW-1:0]       cnt_r;
    logic [2*N_BITS-1:0] acc_next_s;
    logic                mul_last_s;
    logic                mul_ovf_s;

    // Shift-add step; the multiplier sign bit carries weight -2^(N-1), so the last step subtracts.
    always_comb begin
        mul_last_s = (cnt_r == CW'(N_BITS - 1));
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            if (mul_last_s) begin
                acc_next_s = acc_r - mcand_r;
            end else begin
                acc_next_s = acc_r + mcand_r;
            end
        end else begin
            acc_next_s = acc_r;
        end
        mul_ovf_s = !((&acc_next_s[2*N_BITS-1:MSB]) || !(|acc_next_s[2*N_BITS-1:MSB]));
    end
`endif

    // Single-cycle datapath: result and flag terms for the presented opcode.
    always_comb begin
        res_s   = {N_BITS{1'b0}};
        ovf_s   = 1'b0;
        carry_s = 1'b0;
        err_s   = 1'b0;
        sum_s   = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        diff_s  = {1'b0, bus.i_a} - {1'b0, bus.i_b};
        amt_s   = 32'(bus.i_b);
        case (bus.i_op)
            OP_ADD: begin
                res_s   = sum_s[MSB:0];
                carry_s = sum_s[N_BITS];
                ovf_s   = (bus.i_a[MSB] == bus.i_b[MSB]) && (sum_s[MSB] != bus.i_a[MSB]);
            end
            OP_SUB: begin
                res_s   = diff_s[MSB:0];
                carry_s = diff_s[N_BITS];
                ovf_s   = (bus.i_a[MSB] != bus.i_b[MSB]) && (diff_s[MSB] != bus.i_a[MSB]);
            end
            OP_AND: res_s = bus.i_a & bus.i_b;
            OP_OR:  res_s = bus.i_a | bus.i_b;
            OP_XOR: res_s = bus.i_a ^ bus.i_b;
            OP_NOR: res_s = ~(bus.i_a | bus.i_b);
            OP_SRL: begin
                if (amt_s >= 32'(N_BITS)) res_s = {N_BITS{1'b0}};
                else                      res_s = bus.i_a >> amt_s;
            end
            OP_SLL: begin
                if (amt_s >= 32'(N_BITS)) res_s = {N_BITS{1'b0}};
                else                      res_s = bus.i_a << amt_s;
            end
            OP_SRA: begin
                if (amt_s >= 32'(N_BITS)) res_s = {N_BITS{bus.i_a[MSB]}};
                else                      res_s = $signed(bus.i_a) >>> amt_s;
            end
            OP_SLT: res_s = {{(N_BITS-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: res_s = {N_BITS{1'b0}};
`endif
            default: err_s = 1'b1;
        endcase
    end

    assign bus.o_ready  = (state_r == ST_IDLE) && (!valid_r || bus.i_ready);
    assign bus.o_valid  = valid_r;
    assign bus.o_result = result_r;
    assign bus.o_flags  = flags_r;

    // Control FSM and output registers; a consumed result clears valid unless replaced on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            valid_r  <= 1'b0;
            result_r <= {N_BITS{1'b0}};
            flags_r  <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
            acc_r    <= {(2*N_BITS){1'b0}};
            mcand_r  <= {(2*N_BITS){1'b0}};
            mplier_r <= {N_BITS{1'b0}};
            cnt_r    <= {CW{1'b0}};
`endif
        end else begin
            if (valid_r && bus.i_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_valid && bus.o_ready) begin
`ifdef ALU_SEQ_MUL_EN
                        if (bus.i_op == OP_MUL) begin
                            state_r  <= ST_BUSY;
                            acc_r    <= {(2*N_BITS){1'b0}};
                            mcand_r  <= {{N_BITS{bus.i_a[MSB]}}, bus.i_a};
                            mplier_r <= bus.i_b;
                            cnt_r    <= {CW{1'b0}};
                        end else begin
                            valid_r  <= 1'b1;
                            result_r <= res_s;
                            flags_r  <= {err_s, ovf_s, carry_s, (res_s == {N_BITS{1'b0}})};
                        end
`else
                        valid_r  <= 1'b1;
                        result_r <= res_s;
                        flags_r  <= {err_s, ovf_s, carry_s, (res_s == {N_BITS{1'b0}})};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*N_BITS-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[MSB:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (mul_last_s) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= {CW{1'b0}};
                        valid_r  <= 1'b1;
                        result_r <= acc_next_s[MSB:0];
                        flags_r  <= {1'b0, mul_ovf_s, 1'b0, (acc_next_s[MSB:0] == {N_BITS{1'b0}})};
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N_BITS=8); results go through a scoreboard fed by an independent model.
module tb_alu_seq;
    localparam int NB = 8;
    localparam int NO = 6;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110, NOR_ = 6'b100111, SRL = 6'b000010, SRA = 6'b000011;
    localparam logic [5:0] SLL = 6'b000000, SLT = 6'b101010, MUL = 6'b011000, BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];
    logic [11:0] exp_v;

    alu_seq_if #(.N_BITS(NB), .N_OP(NO)) bus();
    alu_seq #(.N_BITS(NB), .N_OP(NO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: {err, ovf, carry, zero, result}
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int sa, sb_, ua, ub, full;
        logic [7:0] r;
        logic e, v, c;
        sa = int'($signed(a)); sb_ = int'($signed(b)); ua = int'(a); ub = int'(b);
        r = 8'h00; e = 1'b0; v = 1'b0; c = 1'b0; full = 0;
        case (op)
            ADD:  begin full = sa + sb_; r = full[7:0]; v = (full > 127) || (full < -128); c = (ua + ub) > 255; end
            SUB:  begin full = sa - sb_; r = full[7:0]; v = (full > 127) || (full < -128); c = ua < ub; end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOR_: r = ~(a | b);
            SRL:  begin full = (ub >= 8) ? 0 : (ua >> ub); r = full[7:0]; end
            SLL:  begin full = (ub >= 8) ? 0 : (ua << ub); r = full[7:0]; end
            SRA:  begin full = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub); r = full[7:0]; end
            SLT:  r = (sa < sb_) ? 8'd1 : 8'd0;
`ifdef ALU_SEQ_MUL_EN
            MUL:  begin full = sa * sb_; r = full[7:0]; v = (full > 127) || (full < -128); end
`endif
            default: e = 1'b1;
        endcase
        return {e, v, c, (r == 8'h00), r};
    endfunction

    // Scoreboard: compare on output transfer, push model result on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got result=%h flags=%b, expected no result", bus.o_result, bus.o_flags);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bus.o_flags, bus.o_result} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_result got flags=%b result=%h, expected flags=%b result=%h",
                                 bus.o_flags, bus.o_result, exp_v[11:8], exp_v[7:0]);
                    end
                end
            end
            if (bus.i_valid && bus.o_ready) sb.push_back(model(bus.i_a, bus.i_b, bus.i_op));
        end
    end

    // Present one op from the posedge+1 phase; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        bit ok;
        ok = 1'b0;
        bus.i_a = a; bus.i_b = b; bus.i_op = op; bus.i_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (bus.o_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout op=%b not accepted within 64 cycles", op);
        end
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        for (int k = 1; k <= limit && cyc == 0; k++) begin
            @(negedge clk);
            if (bus.o_valid) cyc = k;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_a = 8'h00; bus.i_b = 8'h00; bus.i_op = ADD;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_result !== 8'h00 || bus.o_flags !== 4'b0000 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%h f=%b rdy=%b, expected 0 00 0000 1",
                     bus.o_valid, bus.o_result, bus.o_flags, bus.o_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_a = 8'h01; bus.i_b = 8'h02; bus.i_op = ADD; bus.i_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL first_accept got o_ready=%b, expected 1", bus.o_ready);
        end
        @(posedge clk); #1 bus.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_result !== 8'h03) begin
            errors++; $display("FAIL first_result got v=%b r=%h, expected 1 03", bus.o_valid, bus.o_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [7:0] ta[4] = '{8'h7F, 8'h00, 8'h80, 8'h80};
        logic [7:0] tb[4] = '{8'h01, 8'h01, 8'h09, 8'h08};
        logic [5:0] top[4] = '{ADD, SUB, SRA, SRL};
        logic [7:0] tr[4] = '{8'h80, 8'hFF, 8'hFF, 8'h00};
        logic [3:0] tf[4] = '{4'b0100, 4'b0010, 4'b0000, 4'b0001};
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], top[i]);
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== tr[i] || bus.o_flags !== tf[i]) begin
                errors++;
                $display("FAIL directed_%0d got v=%b r=%h f=%b, expected 1 %h %b",
                         i, bus.o_valid, bus.o_result, bus.o_flags, tr[i], tf[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        bus.i_ready = 1'b0;
        issue(8'h10, 8'h20, ADD);
        bus.i_op = OR_; bus.i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== 8'h30 || bus.o_flags !== 4'b0000 || bus.o_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got v=%b r=%h f=%b rdy=%b, expected 1 30 0000 0",
                         k, bus.o_valid, bus.o_result, bus.o_flags, bus.o_ready);
            end
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got o_ready=%b, expected 1", bus.o_ready);
        end
        @(posedge clk); #1 bus.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++; $display("FAIL release_next got o_valid=%b, expected 1", bus.o_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        logic [5:0] ops[11] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRL, SRA, SLL, SLT, BAD};
        logic [5:0] op;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            op = ops[$urandom_range(0, 10)];
            bus.i_op = op; bus.i_a = 8'($urandom);
            bus.i_b = (op == SRL || op == SRA || op == SLL) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            bus.i_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.o_ready !== 1'b1 || (k > 0 && bus.o_valid !== 1'b1)) begin
                errors++;
                $display("FAIL stream_%0d got rdy=%b v=%b, expected 1 1", k, bus.o_ready, bus.o_valid);
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
    endtask

`ifndef ALU_SEQ_MUL_EN
    task automatic test_undef;
        logic [5:0] uops[2] = '{MUL, BAD};
        bus.i_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(8'h5A, 8'h33, uops[i]);
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== 8'h00 || bus.o_flags !== 4'b1001) begin
                errors++;
                $display("FAIL undef_%0d got v=%b r=%h f=%b, expected 1 00 1001",
                         i, bus.o_valid, bus.o_result, bus.o_flags);
            end
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_mul;
        logic [7:0] ma[2] = '{8'hF0, 8'h40};
        logic [7:0] mb[2] = '{8'h03, 8'h04};
        logic [7:0] mr[2] = '{8'hD0, 8'h00};
        logic [3:0] mf[2] = '{4'b0000, 4'b0101};
        int cyc;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(ma[i], mb[i], MUL);
            wait_valid(20, cyc);
            checks++;
            if (cyc != 9) begin
                errors++; $display("FAIL mul_latency_%0d got %0d cycles, expected 9", i, cyc);
            end
            checks++;
            if (bus.o_result !== mr[i] || bus.o_flags !== mf[i]) begin
                errors++;
                $display("FAIL mul_%0d got r=%h f=%b, expected %h %b", i, bus.o_result, bus.o_flags, mr[i], mf[i]);
            end
        end
        // MUL accepted on the same edge a held ADD result is taken
        bus.i_ready = 1'b0;
        issue(8'h05, 8'h06, ADD);
        bus.i_ready = 1'b1;
        issue(8'hFD, 8'h07, MUL);
        wait_valid(20, cyc);
        checks++;
        if (cyc != 9 || bus.o_result !== 8'hEB) begin
            errors++; $display("FAIL mul_after_add got cyc=%0d r=%h, expected 9 eb", cyc, bus.o_result);
        end
        // reset while iterating
        issue(8'h13, 8'h11, MUL);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_result !== 8'h00 || bus.o_flags !== 4'b0000 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_reset got v=%b r=%h f=%b rdy=%b, expected 0 00 0000 1",
                     bus.o_valid, bus.o_result, bus.o_flags, bus.o_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_valid(16, cyc);
        checks++;
        if (cyc != 0) begin
            errors++; $display("FAIL mul_discard got o_valid after %0d cycles, expected none", cyc);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int cyc;
        bus.i_ready = 1'b0;
        issue(8'h11, 8'h22, ADD);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_result !== 8'h00 || bus.o_flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got v=%b r=%h f=%b, expected 0 00 0000", bus.o_valid, bus.o_result, bus.o_flags);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_ready = 1'b1;
        wait_valid(5, cyc);
        checks++;
        if (cyc != 0) begin
            errors++; $display("FAIL reset_mid_idle got o_valid after %0d cycles, expected none", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
`ifndef ALU_SEQ_MUL_EN
        test_undef();
`else
        test_mul();
`endif
        test_reset_mid();
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
